// File: rtl/sdram_burst_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : sdram_burst_scheduler_if
// Purpose  : Operation handshake between the SDRAM burst scheduler and the
//            SDRAM command engine.
// Signals  : op_start  - 1-cycle pulse launching an operation
//            op_type   - 00 none, 01 refresh, 10 write, 11 read
//            op_addr   - burst start address {bank, row, col}
//            op_len    - burst length (0 for refresh)
//            busy      - an operation is outstanding
//            wdog_err  - sticky watchdog flag
//            cmd_done  - 1-cycle pulse from the engine: operation finished
// Modports : master (scheduler side), slave (command engine side)
// Revision : 1.0 - initial release
// ============================================================================
interface sdram_burst_scheduler_if #(
  parameter int ADDR_W = 24,
  parameter int LEN_W  = 10
);
  logic              op_start;
  logic [1:0]        op_type;
  logic [ADDR_W-1:0] op_addr;
  logic [LEN_W-1:0]  op_len;
  logic              busy;
  logic              wdog_err;
  logic              cmd_done;

  modport master (
    output op_start, op_type, op_addr, op_len, busy, wdog_err,
    input  cmd_done
  );

  modport slave (
    input  op_start, op_type, op_addr, op_len, busy, wdog_err,
    output cmd_done
  );
endinterface
`default_nettype wire

// File: rtl/sdram_burst_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sdram_burst_scheduler
// Purpose  : Picks the next SDRAM operation (auto-refresh, write burst that
//            drains the write FIFO, or read burst that fills the VGA FIFO),
//            generates burst addresses with frame wrap and optional
//            ping-pong bank swapping, and issues one operation at a time.
// Ports    : clk, rst          - SDRAM reference clock, sync active-high reset
//            init_done         - SDRAM power-up complete; gates all grants
//            ref_req           - refresh request level
//            wr/rd_fifo_cnt    - FIFO fill levels
//            wr/rd_len         - burst lengths
//            wr/rd_min/max_addr- address windows [min, max)
//            wr/rd_load        - reload the pointer to the window minimum
//            rd_valid          - read path enabled
//            pingpang_en       - two-bank double buffering
//            cmd               - operation handshake (master modport)
// Options  : `define SDRAM_SCHED_WDOG_EN to add a watchdog that aborts an
//            operation lacking cmd_done within WDOG_CYC cycles.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_burst_scheduler #(
  parameter int ADDR_W   = 24,
  parameter int LEN_W    = 10,
  parameter int WDOG_CYC = 1023
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    init_done,
  input  logic                    ref_req,
  input  logic [LEN_W-1:0]        wr_fifo_cnt,
  input  logic [LEN_W-1:0]        rd_fifo_cnt,
  input  logic [LEN_W-1:0]        wr_len,
  input  logic [LEN_W-1:0]        rd_len,
  input  logic [ADDR_W-1:0]       wr_min_addr,
  input  logic [ADDR_W-1:0]       wr_max_addr,
  input  logic [ADDR_W-1:0]       rd_min_addr,
  input  logic [ADDR_W-1:0]       rd_max_addr,
  input  logic                    wr_load,
  input  logic                    rd_load,
  input  logic                    rd_valid,
  input  logic                    pingpang_en,
  sdram_burst_scheduler_if.master cmd
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REF  = 2'd1,
    S_WR   = 2'd2,
    S_RD   = 2'd3
  } state_t;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_REF  = 2'b01;
  localparam logic [1:0] OP_WR   = 2'b10;
  localparam logic [1:0] OP_RD   = 2'b11;

  // The watchdog compare needs at least one cycle of budget.
  if (WDOG_CYC < 1) begin : g_wdog_cyc_invalid
  end

  state_t            state_q, state_d;
  logic              op_start_q, op_start_d;
  logic [1:0]        op_type_q, op_type_d;
  logic [ADDR_W-1:0] op_addr_q, op_addr_d;
  logic [LEN_W-1:0]  op_len_q, op_len_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic              last_wr_q, last_wr_d;      // 1: last data grant was a write
  logic              wr_load_pend_q, wr_load_pend_d;
  logic              rd_load_pend_q, rd_load_pend_d;

  logic              wr_pend, rd_pend, grant_wr, grant_rd;
  logic [ADDR_W:0]   wr_sum, rd_sum;
  logic              wr_wrap, rd_wrap;
  logic [1:0]        wr_bank_bits, rd_bank_bits;
  logic [ADDR_W-1:0] wr_op_addr, rd_op_addr;
  logic              abort;

  assign wr_pend = (wr_fifo_cnt >= wr_len);
  assign rd_pend = rd_valid && (rd_fifo_cnt < rd_len);

  // Round-robin only matters when both sides want the bus.
  assign grant_wr = wr_pend && (!rd_pend || !last_wr_q);
  assign grant_rd = rd_pend && (!wr_pend ||  last_wr_q);

  // One extra bit so the end-of-window compare cannot overflow.
  assign wr_sum  = {1'b0, wr_ptr_q} + (ADDR_W+1)'(wr_len);
  assign rd_sum  = {1'b0, rd_ptr_q} + (ADDR_W+1)'(rd_len);
  assign wr_wrap = (wr_sum >= {1'b0, wr_max_addr});
  assign rd_wrap = (rd_sum >= {1'b0, rd_max_addr});

  assign wr_bank_bits = pingpang_en ? {1'b0, wr_bank_q} : wr_min_addr[ADDR_W-1:ADDR_W-2];
  assign rd_bank_bits = pingpang_en ? {1'b0, rd_bank_q} : rd_min_addr[ADDR_W-1:ADDR_W-2];
  assign wr_op_addr   = {wr_bank_bits, wr_ptr_q[ADDR_W-3:0]};
  assign rd_op_addr   = {rd_bank_bits, rd_ptr_q[ADDR_W-3:0]};

`ifdef SDRAM_SCHED_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYC + 1);

  logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic              wdog_err_q, wdog_err_d;

  // Counter reads 0 in the op_start cycle, so the forced return to IDLE
  // lands exactly WDOG_CYC cycles after op_start.
  assign abort = (state_q != S_IDLE) && !cmd.cmd_done &&
                 (wdog_cnt_q == WDOG_W'(WDOG_CYC - 1));

  always_comb begin
    wdog_cnt_d = wdog_cnt_q;
    wdog_err_d = wdog_err_q | abort;
    if (op_start_d) begin
      wdog_cnt_d = '0;
    end else if (busy_q && !abort) begin
      wdog_cnt_d = wdog_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      wdog_err_q <= wdog_err_d;
    end
  end

  assign cmd.wdog_err = wdog_err_q;
`else
  assign abort        = 1'b0;
  assign cmd.wdog_err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    op_start_d = 1'b0;
    op_type_d  = op_type_q;
    op_addr_d  = op_addr_q;
    op_len_d   = op_len_q;
    busy_d     = busy_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    last_wr_d  = last_wr_q;

    case (state_q)
      S_IDLE: begin
        if (init_done) begin
          if (ref_req) begin
            state_d    = S_REF;
            op_start_d = 1'b1;
            op_type_d  = OP_REF;
            op_addr_d  = '0;
            op_len_d   = '0;
            busy_d     = 1'b1;
          end else if (grant_wr) begin
            state_d    = S_WR;
            op_start_d = 1'b1;
            op_type_d  = OP_WR;
            op_addr_d  = wr_op_addr;
            op_len_d   = wr_len;
            busy_d     = 1'b1;
          end else if (grant_rd) begin
            state_d    = S_RD;
            op_start_d = 1'b1;
            op_type_d  = OP_RD;
            op_addr_d  = rd_op_addr;
            op_len_d   = rd_len;
            busy_d     = 1'b1;
          end
        end
      end

      default: begin
        if (cmd.cmd_done || abort) begin
          state_d   = S_IDLE;
          busy_d    = 1'b0;
          op_type_d = OP_NONE;
          op_addr_d = '0;
          op_len_d  = '0;
        end
        if (cmd.cmd_done && (state_q == S_WR)) begin
          last_wr_d = 1'b1;
          if (wr_load_pend_q) begin
            wr_ptr_d  = wr_min_addr;
            wr_bank_d = 1'b0;
          end else if (wr_wrap) begin
            wr_ptr_d = wr_min_addr;
            if (pingpang_en) begin
              wr_bank_d = ~wr_bank_q;
            end
          end else begin
            wr_ptr_d = wr_sum[ADDR_W-1:0];
          end
        end
        if (cmd.cmd_done && (state_q == S_RD)) begin
          last_wr_d = 1'b0;
          if (rd_load_pend_q) begin
            rd_ptr_d  = rd_min_addr;
            rd_bank_d = 1'b1;
          end else if (rd_wrap) begin
            rd_ptr_d = rd_min_addr;
            // Read follows the last complete frame, never the bank being written.
            if (pingpang_en) begin
              rd_bank_d = ~wr_bank_q;
            end
          end else begin
            rd_ptr_d = rd_sum[ADDR_W-1:0];
          end
        end
      end
    endcase

    // A load takes effect at once; the launched burst keeps its registered
    // address, and the pending flag stops its completion from advancing.
    if (wr_load) begin
      wr_ptr_d  = wr_min_addr;
      wr_bank_d = 1'b0;
    end
    if (rd_load) begin
      rd_ptr_d  = rd_min_addr;
      rd_bank_d = 1'b1;
    end
    wr_load_pend_d = (state_d == S_WR) && (wr_load_pend_q || wr_load);
    rd_load_pend_d = (state_d == S_RD) && (rd_load_pend_q || rd_load);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      op_start_q     <= 1'b0;
      op_type_q      <= OP_NONE;
      op_addr_q      <= '0;
      op_len_q       <= '0;
      busy_q         <= 1'b0;
      wr_ptr_q       <= wr_min_addr;
      rd_ptr_q       <= rd_min_addr;
      wr_bank_q      <= 1'b0;
      rd_bank_q      <= 1'b1;
      last_wr_q      <= 1'b0;
      wr_load_pend_q <= 1'b0;
      rd_load_pend_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_start_q     <= op_start_d;
      op_type_q      <= op_type_d;
      op_addr_q      <= op_addr_d;
      op_len_q       <= op_len_d;
      busy_q         <= busy_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_bank_q      <= wr_bank_d;
      rd_bank_q      <= rd_bank_d;
      last_wr_q      <= last_wr_d;
      wr_load_pend_q <= wr_load_pend_d;
      rd_load_pend_q <= rd_load_pend_d;
    end
  end

  assign cmd.op_start = op_start_q;
  assign cmd.op_type  = op_type_q;
  assign cmd.op_addr  = op_addr_q;
  assign cmd.op_len   = op_len_q;
  assign cmd.busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_burst_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_burst_scheduler
// Purpose  : Self-checking bench for sdram_burst_scheduler: arbitration table
//            plus directed sequences for refresh deferral, pointer load,
//            ping-pong banking, mid-operation reset and the watchdog option.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_burst_scheduler;
  localparam int ADDR_W = 24;
  localparam int LEN_W  = 10;
  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_REF  = 2'b01;
  localparam logic [1:0] OP_WR   = 2'b10;
  localparam logic [1:0] OP_RD   = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, init_done, ref_req, wr_load, rd_load, rd_valid, pingpang_en;
  logic [LEN_W-1:0]  wr_fifo_cnt, rd_fifo_cnt, wr_len, rd_len;
  logic [ADDR_W-1:0] wr_min_addr, wr_max_addr, rd_min_addr, rd_max_addr;

  int checks = 0;
  int errors = 0;

  sdram_burst_scheduler_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) cmd_if ();

  sdram_burst_scheduler #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .WDOG_CYC(1023)) dut (
    .clk(clk), .rst(rst), .init_done(init_done), .ref_req(ref_req),
    .wr_fifo_cnt(wr_fifo_cnt), .rd_fifo_cnt(rd_fifo_cnt),
    .wr_len(wr_len), .rd_len(rd_len),
    .wr_min_addr(wr_min_addr), .wr_max_addr(wr_max_addr),
    .rd_min_addr(rd_min_addr), .rd_max_addr(rd_max_addr),
    .wr_load(wr_load), .rd_load(rd_load), .rd_valid(rd_valid),
    .pingpang_en(pingpang_en), .cmd(cmd_if)
  );

  typedef struct {
    logic              ref_r;
    logic [LEN_W-1:0]  wcnt;
    logic [LEN_W-1:0]  rcnt;
    logic              rvalid;
    logic [1:0]        etype;
    logic [ADDR_W-1:0] eaddr;
    logic [LEN_W-1:0]  elen;
  } vec_t;

  vec_t              vecs [10];
  logic [ADDR_W-1:0] pp_wr_addr [4];
  logic [ADDR_W-1:0] pp_rd_addr [4];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Waits (bounded) for op_start; a grant is expected on the very next negedge.
  task automatic expect_grant(input logic [1:0] t, input logic [ADDR_W-1:0] a,
                              input logic [LEN_W-1:0] l, input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (cmd_if.op_start !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    check({nm, " latency"}, n, 0);
    check({nm, " op_type"}, cmd_if.op_type, t);
    check({nm, " op_addr"}, cmd_if.op_addr, a);
    check({nm, " op_len"},  cmd_if.op_len, l);
    check({nm, " busy"},    cmd_if.busy, 1);
  endtask

  task automatic finish_op(input int hold, input logic [ADDR_W-1:0] a, input string nm);
    @(negedge clk);
    check({nm, " pulse"}, cmd_if.op_start, 0);
    repeat (hold - 1) @(negedge clk);
    check({nm, " addr_hold"}, cmd_if.op_addr, a);
    check({nm, " busy_hold"}, cmd_if.busy, 1);
    cmd_if.cmd_done = 1'b1;
    @(negedge clk);
    cmd_if.cmd_done = 1'b0;
    check({nm, " busy_clr"}, cmd_if.busy, 0);
    check({nm, " type_clr"}, cmd_if.op_type, OP_NONE);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic saw;
    int   k;

    // Table assumes windows [0,1536), length 512, pingpang off, and the
    // pointer/round-robin history accumulated by the preceding entries.
    vecs[0] = '{1'b0, 10'd512,  10'd0,   1'b1, OP_WR, 24'h000000, 10'd512};
    vecs[1] = '{1'b0, 10'd512,  10'd0,   1'b1, OP_RD, 24'h000000, 10'd512};
    vecs[2] = '{1'b0, 10'd512,  10'd0,   1'b1, OP_WR, 24'h000200, 10'd512};
    vecs[3] = '{1'b0, 10'd512,  10'd0,   1'b1, OP_RD, 24'h000200, 10'd512};
    vecs[4] = '{1'b0, 10'd511,  10'd0,   1'b1, OP_RD, 24'h000400, 10'd512};
    vecs[5] = '{1'b0, 10'd1000, 10'd512, 1'b1, OP_WR, 24'h000400, 10'd512};
    vecs[6] = '{1'b0, 10'd512,  10'd511, 1'b1, OP_RD, 24'h000000, 10'd512};
    vecs[7] = '{1'b0, 10'd512,  10'd0,   1'b0, OP_WR, 24'h000000, 10'd512};
    vecs[8] = '{1'b1, 10'd512,  10'd0,   1'b1, OP_REF, 24'h000000, 10'd0};
    vecs[9] = '{1'b0, 10'd512,  10'd0,   1'b1, OP_RD, 24'h000200, 10'd512};
    pp_wr_addr = '{24'h000000, 24'h000200, 24'h000400, 24'h400000};
    pp_rd_addr = '{24'h400000, 24'h400200, 24'h400400, 24'h000000};

    rst = 1'b1; init_done = 1'b0; ref_req = 1'b0; wr_load = 1'b0; rd_load = 1'b0;
    rd_valid = 1'b1; pingpang_en = 1'b0; cmd_if.cmd_done = 1'b0;
    wr_fifo_cnt = 10'd600; rd_fifo_cnt = 10'd600; wr_len = 10'd512; rd_len = 10'd512;
    wr_min_addr = 24'd0; wr_max_addr = 24'd1536; rd_min_addr = 24'd0; rd_max_addr = 24'd1536;
    repeat (3) @(negedge clk);

    check("reset op_start", cmd_if.op_start, 0);
    check("reset op_type",  cmd_if.op_type, OP_NONE);
    check("reset op_addr",  cmd_if.op_addr, 0);
    check("reset op_len",   cmd_if.op_len, 0);
    check("reset busy",     cmd_if.busy, 0);
    check("reset wdog_err", cmd_if.wdog_err, 0);

    // No grant while init_done is low, even with refresh and write pending.
    rst = 1'b0; ref_req = 1'b1;
    saw = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (cmd_if.op_start || cmd_if.busy) saw = 1'b1;
    end
    check("no_grant_before_init", saw, 0);
    init_done = 1'b1;
    expect_grant(OP_REF, 24'h0, 10'd0, "init_ref");
    ref_req = 1'b0;
    finish_op(5, 24'h0, "init_ref");

    for (int i = 0; i < 10; i++) begin
      ref_req     = vecs[i].ref_r;
      wr_fifo_cnt = vecs[i].wcnt;
      rd_fifo_cnt = vecs[i].rcnt;
      rd_valid    = vecs[i].rvalid;
      expect_grant(vecs[i].etype, vecs[i].eaddr, vecs[i].elen, $sformatf("vec%0d", i));
      ref_req = 1'b0;
      finish_op(20, vecs[i].eaddr, $sformatf("vec%0d", i));
    end

    // Refresh arriving mid-write waits, then beats both pending data requests.
    wr_fifo_cnt = 10'd512; rd_fifo_cnt = 10'd0; rd_valid = 1'b1;
    expect_grant(OP_WR, 24'h000200, 10'd512, "refmid_wr");
    repeat (4) @(negedge clk);
    ref_req = 1'b1;
    finish_op(10, 24'h000200, "refmid_wr");
    expect_grant(OP_REF, 24'h0, 10'd0, "refmid_ref");
    ref_req = 1'b0;
    finish_op(5, 24'h0, "refmid_ref");
    expect_grant(OP_RD, 24'h000400, 10'd512, "refmid_rd");
    finish_op(20, 24'h000400, "refmid_rd");

    // wr_load during a write at 1024; window widened so no wrap would hide it.
    wr_max_addr = 24'd4096;
    expect_grant(OP_WR, 24'h000400, 10'd512, "load_wr");
    repeat (3) @(negedge clk);
    wr_load = 1'b1;
    @(negedge clk);
    wr_load = 1'b0;
    finish_op(10, 24'h000400, "load_wr");
    rd_valid = 1'b0;
    expect_grant(OP_WR, 24'h000000, 10'd512, "load_next");
    finish_op(20, 24'h000000, "load_next");
    wr_max_addr = 24'd1536;

    // Ping-pong: write frame wraps into bank 1, read wrap follows ~wr_bank.
    pingpang_en = 1'b1; wr_fifo_cnt = 10'd0; rd_valid = 1'b0;
    wr_load = 1'b1; rd_load = 1'b1;
    @(negedge clk);
    wr_load = 1'b0; rd_load = 1'b0;
    wr_fifo_cnt = 10'd512;
    for (int i = 0; i < 4; i++) begin
      expect_grant(OP_WR, pp_wr_addr[i], 10'd512, $sformatf("pp_wr%0d", i));
      finish_op(20, pp_wr_addr[i], $sformatf("pp_wr%0d", i));
    end
    wr_fifo_cnt = 10'd0; rd_valid = 1'b1; rd_fifo_cnt = 10'd0;
    for (int i = 0; i < 4; i++) begin
      expect_grant(OP_RD, pp_rd_addr[i], 10'd512, $sformatf("pp_rd%0d", i));
      finish_op(20, pp_rd_addr[i], $sformatf("pp_rd%0d", i));
    end

    // Reset mid-read; a stale cmd_done afterwards must be ignored.
    expect_grant(OP_RD, 24'h000200, 10'd512, "rst_rd");
    repeat (3) @(negedge clk);
    rst = 1'b1; init_done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid busy",    cmd_if.busy, 0);
    check("rst_mid op_type", cmd_if.op_type, OP_NONE);
    check("rst_mid op_addr", cmd_if.op_addr, 0);
    cmd_if.cmd_done = 1'b1;
    @(negedge clk);
    cmd_if.cmd_done = 1'b0;
    saw = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (cmd_if.op_start || cmd_if.busy) saw = 1'b1;
    end
    check("stale_done ignored", saw, 0);
    init_done = 1'b1;
    expect_grant(OP_RD, 24'h400000, 10'd512, "post_rst_rd");
    finish_op(20, 24'h400000, "post_rst_rd");

`ifdef SDRAM_SCHED_WDOG_EN
    rd_valid = 1'b0; wr_fifo_cnt = 10'd512;
    expect_grant(OP_WR, 24'h000000, 10'd512, "wdog_wr");
    wr_fifo_cnt = 10'd0;
    k = 0;
    while (cmd_if.busy === 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("wdog cycles", k, 1023);
    check("wdog_err set", cmd_if.wdog_err, 1);
    repeat (5) @(negedge clk);
    check("wdog_err sticky", cmd_if.wdog_err, 1);
    wr_fifo_cnt = 10'd512;
    expect_grant(OP_WR, 24'h000000, 10'd512, "wdog_retry");
    finish_op(20, 24'h000000, "wdog_retry");
    check("wdog_err after retry", cmd_if.wdog_err, 1);
`else
    k = 0;
    check("wdog_err tied low", cmd_if.wdog_err, k[0]);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
